branch_hazard_controller: RTL
=============================

Name: branch_hazard_controller

Overview:
- Decode-stage controller for branches that compare operands in ID.
- Detects when a branch's source registers are still being produced in EX or MEM, and stalls the front end for a counted number of cycles.
- Once the producer reaches MEM, it drives the branch operand forwarding selects (00 regfile, 10 MEM ALU result, 01 MEM load data) and flushes IF/ID on a taken branch.
- Sits between the hazard logic and the ID-stage branch comparator muxes.

Parameters:
- LOAD_STALLS, 1, stall cycles inserted when a load in EX feeds a branch in ID (legal range 1..3).
- CNT_W, 16, width of the saturating stall-cycle statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_rs1  in  5  branch source 1.
- id_rs2  in  5  branch source 2.
- ex_rd  in  5  EX destination.
- ex_reg_write  in  1  EX writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  5  MEM destination.
- mem_reg_write  in  1  MEM writes the register file.
- mem_writeback  in  1  MEM result comes from memory (load).
- branch_taken  in  1  ID comparator outcome, valid only when not stalled.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID register.
- bubble_id_ex  out  1  insert a NOP into ID/EX.
- flush_if_id  out  1  squash the fetched instruction.
- fub_cs_1  out  2  operand 1 forward select.
- fub_cs_2  out  2  operand 2 forward select.
- stall_cycles  out  CNT_W  saturating count of branch-induced stall cycles.

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset). With reset high at a rising edge: state=RUN, cnt=0, stall_cycles=0.
- All outputs are 0 while reset is high, including the combinational ones.
- br = id_valid & id_is_branch.
- Register 0 never matches: any compare with rd==0 is false.
- hz_ex = br & ex_reg_write & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- FSM states: RUN, STALL (cnt is 2 bits).
- RUN, hz_ex=1:
  - stall_pc = stall_if_id = bubble_id_ex = 1; fub selects = 00; flush_if_id = 0.
  - need = ex_mem_read ? LOAD_STALLS : 1.
  - If need>1: next state STALL, cnt = need-1. Otherwise stay in RUN.
- RUN, hz_ex=0:
  - No stall.
  - fub_cs_1 = 10 if br & mem_reg_write & mem_rd!=0 & mem_rd==id_rs1 & !mem_writeback; 01 if the same conditions hold with mem_writeback=1; else 00.
  - fub_cs_2 is derived the same way from id_rs2. The two selects are evaluated independently, so both may be non-zero at once.
  - flush_if_id = br & branch_taken.
- STALL:
  - stall_pc = stall_if_id = bubble_id_ex = 1; fub selects = 00; flush_if_id = 0.
  - EX-stage inputs are ignored because EX holds a bubble.
  - cnt decrements each cycle. When cnt==1, next state is RUN, where hazards are re-evaluated.
- stall_cycles increments on every cycle with stall_pc=1 and saturates at all-ones.
- Simultaneous events:
  - EX and MEM both match the same register: the EX hazard wins (stall). After the stall, the younger producer is in MEM.
  - rs1 matches EX and rs2 matches MEM: stall. Forwarding applies only in the post-stall RUN cycle.
- Non-branch in ID: never stalls and drives 00 selects. Non-branch load-use hazards are handled by the separate hazard unit.
- branch_taken is ignored whenever stalled.
- Reset mid-STALL returns to RUN on the next edge, with the counter and statistics cleared.
- Latency: decisions are combinational within the cycle. Only the stall count and state are registered.

Decomposition:
- Shared package holds:
  - Forward select constants FWD_REG=2'b00, FWD_MEM_ALU=2'b10, FWD_MEM_LOAD=2'b01.
  - The state enum {RUN, STALL}.
  - REG_ZERO=5'd0.
- One sub-module, branch_fwd_select: pure combinational MEM-stage select for a single operand, instantiated twice.
- FSM, counter and statistics stay in the top module.

Test Plan:
- ALU producer: ex add x5, branch beq x5,x6; ex_reg_write=1, ex_mem_read=0 → cycle 0 stall/bubble=1. Cycle 1: mem_rd=5, mem_writeback=0 → fub_cs_1=10, no stall; stall_cycles=1.
- Load producer, LOAD_STALLS=2: ex lw x7, branch on rs2=x7 → stall for exactly 2 cycles with state STALL in cycle 1. Cycle 2: mem_writeback=1 → fub_cs_2=01.
- x0 and dual match: ex_rd=0 with rs1=0 → no stall, fub=00. Then mem_rd=3 with rs1=rs2=3 → fub_cs_1=fub_cs_2=10.
- Taken vs. stalled: branch_taken=1 during a stall → flush=0. branch_taken=1 in the RUN cycle after the stall → flush_if_id=1 for exactly 1 cycle.
- Reset mid-stall: LOAD_STALLS=3, reset asserted in stall cycle 1 → next cycle state=RUN, all outputs 0, stall_cycles=0.
- Saturation: CNT_W=4, 20 consecutive stall cycles → stall_cycles holds 15.

Source files
------------

// File: rtl/branch_hazard_controller_pkg.sv
// branch_hazard_controller_pkg: shared constants, state type and register-match helper
package branch_hazard_controller_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {RUN, STALL} state_t;
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction
endpackage

// File: rtl/branch_fwd_select.sv
// branch_fwd_select: MEM-stage forwarding select for one branch operand
module branch_fwd_select
  import branch_hazard_controller_pkg::*;
(
  input  logic       en,
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       mem_writeback,
  output logic [1:0] sel
);
  // load data or ALU result from MEM when it produces this operand
  always_comb begin
    sel = (en && mem_reg_write && reg_match(mem_rd, rs)) ? (mem_writeback ? FWD_MEM_LOAD : FWD_MEM_ALU) : FWD_REG;
  end
endmodule

// File: rtl/branch_hazard_controller.sv
// branch_hazard_controller: ID-stage branch stall, operand forwarding and flush control
module branch_hazard_controller
  import branch_hazard_controller_pkg::*;
#(
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_writeback,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [1:0]       fub_cs_1,
  output logic [1:0]       fub_cs_2,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [1:0] LOAD_NEED = 2'(LOAD_STALLS);

  if (LOAD_STALLS < 1 || LOAD_STALLS > 3) begin : g_bad_load_stalls
    $error("LOAD_STALLS must be in 1..3");
  end

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n, need;
  logic       br, hz_ex, multi, stall, fwd_en;

  // hazard detection, next state and stall/flush decisions
  always_comb begin
    br = id_valid & id_is_branch;
    hz_ex = br & ex_reg_write & (reg_match(ex_rd, id_rs1) | reg_match(ex_rd, id_rs2));
    need = ex_mem_read ? LOAD_NEED : 2'd1;
    multi = hz_ex && (need > 2'd1);
    state_n = (state == STALL) ? ((cnt == 2'd1) ? RUN : STALL) : (multi ? STALL : RUN);
    cnt_n = (state == STALL) ? cnt - 2'd1 : (multi ? need - 2'd1 : 2'd0);
    stall = !reset && ((state == STALL) || hz_ex);
    fwd_en = !reset && br && !stall;
    stall_pc = stall;
    stall_if_id = stall;
    bubble_id_ex = stall;
    flush_if_id = fwd_en & branch_taken;
  end

  // state and remaining-stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= 2'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end

  // saturating count of branch-induced stall cycles
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end

  branch_fwd_select u_fwd1 (
    .en(fwd_en), .rs(id_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_writeback(mem_writeback), .sel(fub_cs_1)
  );

  branch_fwd_select u_fwd2 (
    .en(fwd_en), .rs(id_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_writeback(mem_writeback), .sel(fub_cs_2)
  );
endmodule
